io_intr_unit: RTL
=================

IO_INTR_UNIT -- requirements
Module: io_intr_unit

Interface
REQ-001 Parameter: DATA_W, 8, width of INPR/OUTR and device data paths.
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 io_exec  in  1  one-cycle strobe from controller: register-reference I/O instruction at T3 (D7 & I).
REQ-005 io_bits  in  6  IR[11:6]: INP, OUT, SKI, SKO, ION, IOF (MSB first); valid only with io_exec.
REQ-006 t012  in  1  high while the sequence counter is in T0, T1 or T2.
REQ-007 intr_ack  in  1  one-cycle strobe at end of interrupt cycle (RT2).
REQ-008 ac_lo  in  DATA_W  AC[7:0], source for OUT.
REQ-009 inpr  out  DATA_W  input register, bus source for INP.
REQ-010 inp_load  out  1  AC[7:0] <- INPR strobe.
REQ-011 skip  out  1  PC <- PC+1 request.
REQ-012 intr_req  out  1  interrupt flip-flop R.
REQ-013 ien  out  1  interrupt enable.
REQ-014 rx_valid / rx_data / rx_ready  in / in DATA_W / out  input device handshake.
REQ-015 tx_valid / tx_data / tx_ready  out / out DATA_W / in  output device handshake.
REQ-016 ovr_err  out  1  sticky: OUT issued while output busy.

Function
REQ-017 inp_load, skip: combinational, same cycle as io_exec; all other outputs registered.
REQ-018 io_bits decode: highest set bit only acts (INP > OUT > SKI > SKO > ION > IOF); io_bits = 0 -> no action.
REQ-019 Receive: rx_ready = ~FGI; rx_valid & rx_ready -> INPR <= rx_data, FGI <= 1 next edge.
REQ-020 INP: inp_load = 1 for the io_exec cycle; FGI <= 0 next edge; INPR held.
REQ-021 INP with FGI = 0: inp_load still asserted (stale INPR), no error.
REQ-022 Transmit FSM states TX_IDLE (FGO = 1), TX_SEND (FGO = 0).
REQ-023 OUT in TX_IDLE: OUTR <= ac_lo, state -> TX_SEND next edge.
REQ-024 TX_SEND: tx_valid = 1, tx_data = OUTR stable; tx_valid & tx_ready -> TX_IDLE next edge; zero extra latency.
REQ-025 OUT in TX_SEND: dropped, OUTR unchanged, ovr_err <= 1 (cleared only by reset).
REQ-026 SKI: skip = FGI; SKO: skip = FGO (current-cycle flag values).
REQ-027 ION: IEN <= 1; IOF: IEN <= 0.
REQ-028 R <= 1 on edge when ~t012 & IEN & (FGI | FGO) & ~intr_ack.
REQ-029 intr_ack: R <= 0 and IEN <= 0 next edge; ack wins over ION and over R-set in same cycle.
REQ-030 Simultaneous handshake completion and SKO in same cycle: skip uses pre-edge FGO (0).

Reset
REQ-031 rst_n low, asynchronously: FGI = 0, FGO = 1 (TX_IDLE), IEN = 0, R = 0, INPR = 0, OUTR = 0, ovr_err = 0.
REQ-032 Reset mid-TX_SEND: tx_valid drops immediately; in-flight byte lost.
REQ-033 Outputs rx_ready = 1, tx_valid = 0 while rst_n low.

Structure
REQ-034 Shared package bc_pkg: io_bits index constants (IO_INP = 5 ... IO_IOF = 0), tx state enum, DATA_W default.
REQ-035 One sub-module io_tx_fsm (OUTR, FGO, handshake, ovr_err); rest flat in io_intr_unit.

Verification
REQ-036 rx_valid, rx_data = 0x5A -> FGI = 1, rx_ready = 0; io_exec, io_bits = 100000 -> inp_load = 1, inpr = 0x5A, FGI = 0 next cycle.
REQ-037 ac_lo = 0xC3, OUT -> tx_valid = 1, tx_data = 0xC3; tx_ready held 0 three cycles then 1 -> tx_valid = 0 next cycle, FGO = 1.
REQ-038 Second OUT (ac_lo = 0x11) during TX_SEND -> tx_data stays 0xC3, ovr_err = 1.
REQ-039 ION, FGI = 1, t012 = 0 -> intr_req = 1 next edge; intr_ack -> intr_req = 0, ien = 0; t012 = 1 blocks set.
REQ-040 io_bits = 001100 with FGI = 1, FGO = 0 -> skip = 1 (SKI priority); io_bits = 000100 -> skip = 0.
REQ-041 rst_n low mid-TX_SEND -> tx_valid = 0 same cycle, all REQ-031 values.

Source files
------------

// File: rtl/bc_pkg.sv
// Shared constants for the basic-computer I/O and interrupt slice:
// IR[11:6] bit positions, transmit state encoding and default data width.
package bc_pkg;

    localparam int unsigned BC_DATA_W = 8;

    // Bit positions inside io_bits (IR[11:6]), MSB first
    localparam int unsigned IO_INP = 5;
    localparam int unsigned IO_OUT = 4;
    localparam int unsigned IO_SKI = 3;
    localparam int unsigned IO_SKO = 2;
    localparam int unsigned IO_ION = 1;
    localparam int unsigned IO_IOF = 0;

    // TX_IDLE corresponds to FGO = 1, TX_SEND to FGO = 0
    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/io_tx_fsm.sv
// Output side: OUTR, FGO (as the transmit state), valid/ready handshake
// toward the output device, and the sticky overrun flag.
module io_tx_fsm
    import bc_pkg::*;
#(
    parameter int unsigned DATA_W = BC_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              out_cmd,
    input  logic [DATA_W-1:0] ac_lo,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              fgo,
    output logic              ovr_err
);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] outr_q, outr_d;
    logic              ovr_q, ovr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            outr_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            outr_q  <= outr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        outr_d   = outr_q;
        ovr_d    = ovr_q;
        tx_valid = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (out_cmd) begin
                    outr_d  = ac_lo;
                    state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_d = TX_IDLE;
                end
                // An OUT while busy is discarded; OUTR keeps the in-flight byte
                if (out_cmd) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign tx_data = outr_q;
    assign fgo     = (state_q == TX_IDLE);
    assign ovr_err = ovr_q;

endmodule

// File: rtl/io_intr_unit.sv
// Register-reference I/O instruction decode, input register/FGI,
// interrupt enable and interrupt request flip-flop R.
module io_intr_unit
    import bc_pkg::*;
#(
    parameter int unsigned DATA_W = BC_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              io_exec,
    input  logic [5:0]        io_bits,
    input  logic              t012,
    input  logic              intr_ack,
    input  logic [DATA_W-1:0] ac_lo,
    output logic [DATA_W-1:0] inpr,
    output logic              inp_load,
    output logic              skip,
    output logic              intr_req,
    output logic              ien,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic              ovr_err
);

    logic              do_inp, do_out, do_ski, do_sko, do_ion, do_iof;
    logic              fgi_q;
    logic              fgo;
    logic [DATA_W-1:0] inpr_q;
    logic              ien_q;
    logic              r_q;

    // Priority decode: only the highest set bit of io_bits acts
    always_comb begin
        do_inp = 1'b0;
        do_out = 1'b0;
        do_ski = 1'b0;
        do_sko = 1'b0;
        do_ion = 1'b0;
        do_iof = 1'b0;
        if (io_exec) begin
            if (io_bits[IO_INP])      do_inp = 1'b1;
            else if (io_bits[IO_OUT]) do_out = 1'b1;
            else if (io_bits[IO_SKI]) do_ski = 1'b1;
            else if (io_bits[IO_SKO]) do_sko = 1'b1;
            else if (io_bits[IO_ION]) do_ion = 1'b1;
            else if (io_bits[IO_IOF]) do_iof = 1'b1;
        end
    end

    assign inp_load = do_inp;
    assign skip     = (do_ski & fgi_q) | (do_sko & fgo);
    assign rx_ready = ~fgi_q;

    // A byte accepted in the same cycle as a stale INP (FGI = 0) still sets FGI
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fgi_q  <= 1'b0;
            inpr_q <= '0;
        end else if (rx_valid && !fgi_q) begin
            fgi_q  <= 1'b1;
            inpr_q <= rx_data;
        end else if (do_inp) begin
            fgi_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ien_q <= 1'b0;
            r_q   <= 1'b0;
        end else begin
            if (intr_ack)    ien_q <= 1'b0;
            else if (do_ion) ien_q <= 1'b1;
            else if (do_iof) ien_q <= 1'b0;

            if (intr_ack)                                r_q <= 1'b0;
            else if (!t012 && ien_q && (fgi_q || fgo))   r_q <= 1'b1;
        end
    end

    io_tx_fsm #(
        .DATA_W (DATA_W)
    ) u_tx_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .out_cmd  (do_out),
        .ac_lo    (ac_lo),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .fgo      (fgo),
        .ovr_err  (ovr_err)
    );

    assign inpr     = inpr_q;
    assign ien      = ien_q;
    assign intr_req = r_q;

endmodule
